timers_gen_counter: RTL and testbench

// - Generic timer/counter for the timers subsystem. It replaces the fixed-width, mode-decoded timer channels.
// - WIDTH-bit counter with four modes: free-run up, up with auto-reload, down with auto-reload, hold.
// - Count source is an internal prescaled clock tick or a synchronised external event pin; counting can be gated by an interrupt pin.
// - Outputs a sticky overflow flag (TF) for the SFR/interrupt logic and a one-cycle overflow pulse for chaining.

---
 rtl/timers_gen_counter.sv | 130 +++++++++++++
 tb/tb_timers_gen_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/timers_gen_counter.sv
// Generic timer/counter: WIDTH-bit count with free-run, up-reload, down-reload
// and hold modes, clocked by a prescaled tick or a synchronised external pin.
module timers_gen_counter #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  timers_clock_i,
  input  logic                  timers_reset_i,
  input  logic                  timers_run_i,
  input  logic                  timers_gate_i,
  input  logic                  timers_int_i,
  input  logic                  timers_ext_i,
  input  logic                  timers_src_ext_i,
  input  logic [1:0]            timers_mode_i,
  input  logic [PRESCALE_W-1:0] timers_presc_i,
  input  logic [WIDTH-1:0]      timers_reload_i,
  input  logic                  timers_load_i,
  input  logic [WIDTH-1:0]      timers_load_val_i,
  input  logic                  timers_tf_clr_i,
  output logic [WIDTH-1:0]      timers_count_o,
  output logic                  timers_tf_o,
  output logic                  timers_ovf_o
);

  typedef enum logic [1:0] {
    MODE_UP          = 2'b00,
    MODE_UP_RELOAD   = 2'b01,
    MODE_DOWN_RELOAD = 2'b10,
    MODE_HOLD        = 2'b11
  } mode_e;

  mode_e                 mode;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  tf_q, tf_d;
  logic                  ovf_q, ovf_d;
  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic                  s3_q, s3_d;
  logic                  run_en;
  logic                  tick_int;
  logic                  tick_ext;
  logic                  tick;

  assign mode = mode_e'(timers_mode_i);

  // Next-state logic: sync chain, prescaler, counter, overflow and TF.
  always_comb begin
    s1_d    = timers_ext_i;
    s2_d    = s1_q;
    s3_d    = s2_q;
    count_d = count_q;
    presc_d = presc_q;
    ovf_d   = 1'b0;

    run_en   = timers_run_i && (!timers_gate_i || timers_int_i) && (mode != MODE_HOLD);
    tick_int = run_en && (presc_q == timers_presc_i);
    tick_ext = s2_q && !s3_q && run_en;
    tick     = timers_src_ext_i ? tick_ext : tick_int;

    // The prescaler only advances for the internal source; it is left
    // untouched (not cleared) while counting external events.
    if (!timers_src_ext_i && run_en) begin
      presc_d = tick_int ? '0 : presc_q + PRESCALE_W'(1);
    end

    if (tick) begin
      case (mode)
        MODE_UP: begin
          count_d = count_q + WIDTH'(1);
          ovf_d   = (count_q == '1);
        end
        MODE_UP_RELOAD: begin
          if (count_q == '1) begin
            count_d = timers_reload_i;
            ovf_d   = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        MODE_DOWN_RELOAD: begin
          if (count_q == '0) begin
            count_d = timers_reload_i;
            ovf_d   = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end

    if (timers_load_i) begin
      count_d = timers_load_val_i;
      presc_d = '0;
      ovf_d   = 1'b0;
    end

    // Set wins over a coincident clear.
    tf_d = ovf_d ? 1'b1 : (timers_tf_clr_i ? 1'b0 : tf_q);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge timers_clock_i) begin
    if (timers_reset_i) begin
      count_q <= '0;
      presc_q <= '0;
      tf_q    <= 1'b0;
      ovf_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      tf_q    <= tf_d;
      ovf_q   <= ovf_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
    end
  end

  assign timers_count_o = count_q;
  assign timers_tf_o    = tf_q;
  assign timers_ovf_o   = ovf_q;

endmodule

// File: tb/tb_timers_gen_counter.sv
// Bench for timers_gen_counter (WIDTH=8, PRESCALE_W=4): directed scenarios
// followed by random traffic, all checked against a cycle-level model.
module tb_timers_gen_counter;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 4;
  localparam int MAXC = (1 << W) - 1;
  localparam int PMOD = 1 << PW;

  logic          clk = 1'b0;
  logic          rst, run, gate, intp, ext, src_ext, load, tf_clr;
  logic [1:0]    mode;
  logic [PW-1:0] presc;
  logic [W-1:0]  reload, load_val;
  logic [W-1:0]  count;
  logic          tf, ovf;

  int n_pass = 0;
  int n_total = 0;

  // Reference state
  int m_count, m_presc, m_tf, m_ovf;
  int m_s1, m_s2, m_s3;

  timers_gen_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .timers_clock_i    (clk),
    .timers_reset_i    (rst),
    .timers_run_i      (run),
    .timers_gate_i     (gate),
    .timers_int_i      (intp),
    .timers_ext_i      (ext),
    .timers_src_ext_i  (src_ext),
    .timers_mode_i     (mode),
    .timers_presc_i    (presc),
    .timers_reload_i   (reload),
    .timers_load_i     (load),
    .timers_load_val_i (load_val),
    .timers_tf_clr_i   (tf_clr),
    .timers_count_o    (count),
    .timers_tf_o       (tf),
    .timers_ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance the model by one clock edge from the currently driven inputs.
  task automatic model_edge();
    int en, tk, nc, no;
    if (rst) begin
      m_count = 0; m_presc = 0; m_tf = 0; m_ovf = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      return;
    end
    en = (run && (!gate || intp) && mode != 2'd3) ? 1 : 0;
    if (src_ext) tk = (m_s2 == 1 && m_s3 == 0 && en == 1) ? 1 : 0;
    else         tk = (en == 1 && m_presc == int'(presc)) ? 1 : 0;
    nc = m_count;
    no = 0;
    if (tk == 1) begin
      if (mode == 2'd0) begin
        if (m_count == MAXC) begin nc = 0; no = 1; end else nc = m_count + 1;
      end else if (mode == 2'd1) begin
        if (m_count == MAXC) begin nc = int'(reload); no = 1; end else nc = m_count + 1;
      end else if (mode == 2'd2) begin
        if (m_count == 0) begin nc = int'(reload); no = 1; end else nc = m_count - 1;
      end
    end
    if (!src_ext && en == 1)
      m_presc = (m_presc == int'(presc)) ? 0 : (m_presc + 1) % PMOD;
    if (load) begin
      nc = int'(load_val); no = 0; m_presc = 0;
    end
    m_count = nc;
    m_ovf   = no;
    if (no == 1) m_tf = 1;
    else if (tf_clr) m_tf = 0;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = int'(ext);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, "/count"}, int'(count), m_count);
    chk({tag, "/tf"},    int'(tf),    m_tf);
    chk({tag, "/ovf"},   int'(ovf),   m_ovf);
  endtask

  initial begin
    int c0;
    rst = 1'b0; run = 1'b1; gate = 1'b0; intp = 1'b0; ext = 1'b0;
    src_ext = 1'b0; load = 1'b0; tf_clr = 1'b0; mode = 2'd0;
    presc = '0; reload = '0; load_val = '0;
    m_count = 0; m_presc = 0; m_tf = 0; m_ovf = 0;
    m_s1 = 0; m_s2 = 0; m_s3 = 0;
    @(negedge clk);

    // Reset while counting
    rst = 1'b1; step("reset"); step("reset");
    chk("reset_const_count", int'(count), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("free_run");
    rst = 1'b1; step("reset_mid");
    chk("reset_mid_const", int'(count), 0);
    rst = 1'b0;

    // Mode 00 wrap, sticky TF
    load = 1'b1; load_val = 8'hFE; step("m00_load"); load = 1'b0;
    step("m00_ff");
    step("m00_wrap");
    chk("m00_wrap_ovf_const", int'(ovf), 1);
    for (int i = 0; i < 3; i++) step("m00_tf_sticky");
    chk("m00_tf_sticky_const", int'(tf), 1);
    tf_clr = 1'b1; step("m00_tf_clr"); tf_clr = 1'b0;

    // Mode 01 reload, divide by 3
    mode = 2'd1; reload = 8'hF0; presc = 4'd2;
    load = 1'b1; load_val = 8'hFF; step("m01_load"); load = 1'b0;
    for (int i = 0; i < 10; i++) step("m01");

    // Mode 10 down with reload
    mode = 2'd2; reload = 8'h05; presc = 4'd0;
    load = 1'b1; load_val = 8'h01; step("m10_load"); load = 1'b0;
    for (int i = 0; i < 4; i++) step("m10");

    // Gating
    mode = 2'd0; presc = 4'd1; gate = 1'b1; intp = 1'b0;
    for (int i = 0; i < 3; i++) step("gate_hold");
    intp = 1'b1;
    for (int i = 0; i < 4; i++) step("gate_resume");
    gate = 1'b0;

    // External pulses: update lands on the 3rd edge after first high sample
    src_ext = 1'b1;
    load = 1'b1; load_val = 8'h10; step("ext_load"); load = 1'b0;
    for (int p = 0; p < 3; p++) begin
      c0 = int'(count);
      ext = 1'b1; step("ext_hi"); step("ext_hi");
      chk("ext_latency_hold", int'(count), c0);
      ext = 1'b0; step("ext_edge");
      chk("ext_latency_inc", int'(count), (c0 + 1) % (MAXC + 1));
      step("ext_lo"); step("ext_lo");
    end
    src_ext = 1'b0;

    // TF clear coincident with overflow
    presc = 4'd0;
    load = 1'b1; load_val = 8'hFF; step("clr_ovf_load"); load = 1'b0;
    tf_clr = 1'b1; step("clr_vs_set"); tf_clr = 1'b0;
    chk("clr_vs_set_const", int'(tf), 1);

    // Load coincident with tick
    step("pre_load_tick");
    load = 1'b1; load_val = 8'h33; step("load_vs_tick"); load = 1'b0;
    chk("load_vs_tick_const", int'(count), 8'h33);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      run      = ($urandom_range(0, 7) != 0);
      gate     = $urandom_range(0, 1) == 1;
      intp     = $urandom_range(0, 1) == 1;
      ext      = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) src_ext = ~src_ext;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) presc = PW'($urandom_range(0, 3));
      reload   = W'($urandom_range(0, MAXC));
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom_range(MAXC - 8, MAXC));
      tf_clr   = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
